// File: rtl/small_fifo_fwft.sv
// First-word-fall-through FIFO: memory plus one registered output stage, occupancy count,
// overflow/underflow flags. Define SMALL_FIFO_ERR_STICKY_EN for sticky error flags.
module small_fifo_fwft #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic                    nearly_full,
  output logic [MAX_DEPTH_BITS:0] data_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] CNT_FULL = (MAX_DEPTH_BITS+1)'(MAX_DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] CNT_NF   = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);

  logic [WIDTH-1:0]          mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic                      out_valid;
  logic [MAX_DEPTH_BITS:0]   count_q;
  logic [MAX_DEPTH_BITS:0]   mem_count;
  logic                      wr_acc;
  logic                      wr_rej;
  logic                      rd_acc;
  logic                      rd_rej;
  logic                      mem_nonempty;
  logic                      refill;

  // Handshake: the producer side is ready while !full (or while a pop happens on the same
  // edge); the consumer side sees valid = !empty with dout stable, and rd_en pops that word.
  assign empty       = !out_valid;
  assign full        = (count_q == CNT_FULL);
  assign nearly_full = (count_q >= CNT_NF);
  assign data_count  = count_q;

  assign wr_acc = wr_en && (!full || rd_en);
  assign wr_rej = wr_en && full && !rd_en;
  assign rd_acc = rd_en && out_valid;
  assign rd_rej = rd_en && !out_valid;

  // Words still in memory are everything counted that is not sitting in the output stage.
  assign mem_count    = count_q - {{MAX_DEPTH_BITS{1'b0}}, out_valid};
  assign mem_nonempty = (mem_count != '0);
  assign refill       = (!out_valid || rd_acc) && mem_nonempty;

  // Storage carries no reset; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (refill) begin
        dout      <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end

      if (wr_acc && !rd_acc) begin
        count_q <= count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - 1'b1;
      end

`ifdef SMALL_FIFO_ERR_STICKY_EN
      overflow  <= overflow  | wr_rej;
      underflow <= underflow | rd_rej;
`else
      overflow  <= wr_rej;
      underflow <= rd_rej;
`endif
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && wr_rej) begin
      $display("%0t %m: write dropped, fifo full", $time);
    end
    if (reset_n && rd_rej) begin
      $display("%0t %m: read dropped, fifo empty", $time);
    end
  end
`endif

endmodule

// File: tb/tb_small_fifo_fwft.sv
// Directed table-driven bench for small_fifo_fwft, plus reset and queue-model sequences.
module tb_small_fifo_fwft;

  localparam int W = 72;

`ifdef SMALL_FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         empty;
  logic         full;
  logic         nearly_full;
  logic [3:0]   data_count;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int errors = 0;

  small_fifo_fwft dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .nearly_full (nearly_full),
    .data_count  (data_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         empty;
    logic         full;
    logic         nf;
    logic [3:0]   cnt;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] exp_q[$];

  function automatic vec_t mk(logic wr, logic rd, logic [W-1:0] d, logic [W-1:0] o,
                              logic e, logic f, logic nf, logic [3:0] c, logic ov, logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.dout = o; v.empty = e;
    v.full = f; v.nf = nf; v.cnt = c; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply inputs for one cycle, return #1 after the edge
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dout"},        dout, '0);
    chk({tag, " empty"},       W'(empty), W'(1));
    chk({tag, " full"},        W'(full), W'(0));
    chk({tag, " nearly_full"}, W'(nearly_full), W'(0));
    chk({tag, " data_count"},  W'(data_count), W'(0));
    chk({tag, " overflow"},    W'(overflow), W'(0));
    chk({tag, " underflow"},   W'(underflow), W'(0));
  endtask

  initial begin
    logic seen_ovf;
    logic seen_unf;
    logic wr_r;
    logic rd_r;
    logic wr_ok;
    logic [W-1:0] d_r;

    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    seen_ovf = 1'b0;
    seen_unf = 1'b0;

    // stimulus table: {wr, rd, din} -> state after the edge (ovf/unf as pulse values)
    tbl.push_back(mk(1, 0, 'hA5, 'h00, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 'hA5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'hA5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'hA5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 'h00, 'hA5, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 'h01, 'h00, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 0, 'h02, 'h00, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(1, 0, 'h03, 'h00, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(1, 0, 'h04, 'h00, 0, 0, 0, 5, 0, 0));
    tbl.push_back(mk(1, 0, 'h05, 'h00, 0, 0, 0, 6, 0, 0));
    tbl.push_back(mk(1, 0, 'h06, 'h00, 0, 0, 1, 7, 0, 0));
    tbl.push_back(mk(1, 0, 'h07, 'h00, 0, 1, 1, 8, 0, 0));
    tbl.push_back(mk(1, 0, 'h99, 'h00, 0, 1, 1, 8, 1, 0));
    tbl.push_back(mk(1, 1, 'h55, 'h01, 0, 1, 1, 8, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h02, 0, 0, 1, 7, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h03, 0, 0, 0, 6, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h04, 0, 0, 0, 5, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h05, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h06, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h07, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h55, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h55, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h55, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 'h00, 'h55, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 'h11, 'h55, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 'h11, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 'h22, 'h11, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 'h22, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 'h00, 'h22, 1, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      seen_ovf = seen_ovf | tbl[i].ovf;
      seen_unf = seen_unf | tbl[i].unf;
      chk($sformatf("v%0d dout", i),        dout, tbl[i].dout);
      chk($sformatf("v%0d empty", i),       W'(empty), W'(tbl[i].empty));
      chk($sformatf("v%0d full", i),        W'(full), W'(tbl[i].full));
      chk($sformatf("v%0d nearly_full", i), W'(nearly_full), W'(tbl[i].nf));
      chk($sformatf("v%0d data_count", i),  W'(data_count), W'(tbl[i].cnt));
      chk($sformatf("v%0d overflow", i),    W'(overflow),
          W'(STICKY ? seen_ovf : tbl[i].ovf));
      chk($sformatf("v%0d underflow", i),   W'(underflow),
          W'(STICKY ? seen_unf : tbl[i].unf));
    end

    // asynchronous reset in the middle of a write burst with 5 words stored
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, W'(8'h10 + i));
    end
    chk("burst data_count", W'(data_count), W'(5));
    chk("burst dout", dout, W'(8'h10));
    wr_en = 1'b1;
    din   = W'(8'h15);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    wr_en = 1'b0;
    #2;
    reset_n = 1'b1;
    step(1'b1, 1'b0, W'(8'h3C));
    chk("post_reset data_count", W'(data_count), W'(1));
    chk("post_reset empty", W'(empty), W'(1));
    step(1'b0, 1'b0, '0);
    chk("post_reset dout", dout, W'(8'h3C));
    chk("post_reset empty2", W'(empty), W'(0));
    step(1'b0, 1'b1, '0);
    chk("post_reset drained", W'(data_count), W'(0));

    // queue-model phase: random traffic, reads only while a word is shown
    exp_q.delete();
    for (int c = 0; c < 240; c++) begin
      chk($sformatf("rnd%0d data_count", c), W'(data_count), W'(exp_q.size()));
      if (c < 120) begin
        wr_r = ($urandom_range(0, 9) < 7);
        rd_r = !empty && ($urandom_range(0, 9) < 3);
      end else begin
        wr_r = ($urandom_range(0, 9) < 3);
        rd_r = !empty && ($urandom_range(0, 9) < 7);
      end
      d_r = {$urandom(), $urandom(), 8'($urandom())};
      if (rd_r) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("rnd%0d shown_without_data", c), W'(empty), W'(1));
          rd_r = 1'b0;
        end else begin
          chk($sformatf("rnd%0d dout", c), dout, exp_q[0]);
        end
      end
      wr_ok = wr_r && ((exp_q.size() < 8) || rd_r);
      step(wr_r, rd_r, d_r);
      if (rd_r) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(d_r);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
